// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Contents: FSM state enum, access-size codes, byte counts, load extension.
// Ports: none (package).
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;

  localparam logic [2:0] NB_BYTE = 3'd1;
  localparam logic [2:0] NB_HALF = 3'd2;
  localparam logic [2:0] NB_WORD = 3'd4;

  // mem_byte wins over mem_half_word; neither set means a word.
  function automatic size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

  function automatic logic [2:0] size_bytes(input size_t size);
    case (size)
      SZ_BYTE: return NB_BYTE;
      SZ_HALF: return NB_HALF;
      default: return NB_WORD;
    endcase
  endfunction

  // raw holds mem[a..a+3] with mem[a] in raw[0:7]; the sub-word is moved
  // to the low-order end and the upper bits filled from its MSB or zero.
  function automatic logic [0:31] load_extend(input logic [0:31] raw,
                                              input size_t size,
                                              input logic sign_extend);
    logic fill;
    fill = sign_extend & raw[0];
    case (size)
      SZ_BYTE: return {{24{fill}}, raw[0:7]};
      SZ_HALF: return {{16{fill}}, raw[0:15]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a processor and the memory responder.
// master: processor side (drives request fields); slave: responder side.
// Signals: req_valid/req_ready handshake, access fields, resp_valid/data_out/error.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:31] addr;
  logic        write_enable;
  logic        mem_byte;
  logic        mem_half_word;
  logic        sign_extend;
  logic [0:31] data_in;
  logic        resp_valid;
  logic [0:31] data_out;
  logic        error;

  modport master (
    output req_valid, addr, write_enable, mem_byte, mem_half_word, sign_extend, data_in,
    input  req_ready, resp_valid, data_out, error
  );

  modport slave (
    input  req_valid, addr, write_enable, mem_byte, mem_half_word, sign_extend, data_in,
    output req_ready, resp_valid, data_out, error
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational big-endian lane steering: store bytes to lanes, load extension.
// Latency: none (pure combinational); no handshake, no state.
// Ports: size/sign_extend select; wdata -> wlanes/lane_en; rdata_raw -> rdata.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic        sign_extend,
  input  logic [0:31] wdata,
  input  logic [0:31] rdata_raw,
  output logic [0:31] wlanes,
  output logic [0:3]  lane_en,
  output logic [0:31] rdata
);

  // Lane 0 is mem[a]; sub-word store data is taken from the low-order bits.
  always_comb begin
    wlanes  = wdata;
    lane_en = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wlanes  = {wdata[24:31], 24'h0};
        lane_en = 4'b1000;
      end
      SZ_HALF: begin
        wlanes  = {wdata[16:31], 16'h0};
        lane_en = 4'b1100;
      end
      default: ;
    endcase
  end

  assign rdata = load_extend(rdata_raw, size, sign_extend);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle byte-array data memory with LATENCY wait states per access.
// Latency: response LATENCY+1 cycles after acceptance; one access per LATENCY+2 cycles.
// Ports: clock, reset (async active-low), bus (slave modport); req_ready only in IDLE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  // Index width assumes SIZE is a power of two; bytes past the end of a
  // sub-word wrap harmlessly because they are never used.
  localparam int AW = $clog2(SIZE);

  logic [0:7] mem [0:SIZE-1];

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [0:31] l_addr, l_wdata;
  logic        l_we, l_se;
  size_t       l_size;

  logic        accept, commit, err;
  logic [0:31] c_addr, c_wdata;
  logic        c_we, c_se;
  size_t       c_size;
  logic [32:0] end_addr;
  logic [AW-1:0] base;
  logic [AW-1:0] idx [0:3];
  logic [0:31] raw, wlanes, rdata;
  logic [0:3]  lane_en;
  logic [0:31] data_q;
  logic        error_q;

  assign accept = (state == IDLE) && bus.req_valid;

  // With no wait states the access commits on the acceptance edge, so the
  // live request fields are used; otherwise the latched copy is.
  assign c_addr  = (LATENCY == 0) ? bus.addr : l_addr;
  assign c_wdata = (LATENCY == 0) ? bus.data_in : l_wdata;
  assign c_we    = (LATENCY == 0) ? bus.write_enable : l_we;
  assign c_se    = (LATENCY == 0) ? bus.sign_extend : l_se;
  assign c_size  = (LATENCY == 0) ? decode_size(bus.mem_byte, bus.mem_half_word) : l_size;

  // Reset gates the commit so an in-flight store never lands in mem.
  assign commit = reset && ((LATENCY == 0) ? accept : (state == WAIT && cnt == 4'd0));

  assign end_addr = {1'b0, c_addr} + {30'b0, size_bytes(c_size)};
  assign err = ((c_size == SZ_HALF) && c_addr[31]) ||
               ((c_size == SZ_WORD) && (c_addr[30:31] != 2'b00)) ||
               (end_addr > 33'(SIZE));

  assign base = c_addr[32-AW:31];
  always_comb begin
    for (int i = 0; i < 4; i++) idx[i] = base + AW'(i);
  end
  assign raw = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};

  dmem_lane_align u_align (
    .size        (c_size),
    .sign_extend (c_se),
    .wdata       (c_wdata),
    .rdata_raw   (raw),
    .wlanes      (wlanes),
    .lane_en     (lane_en),
    .rdata       (rdata)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (commit && c_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx[i]] <= wlanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_we    <= 1'b0;
      l_se    <= 1'b0;
      l_size  <= SZ_WORD;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        l_addr  <= bus.addr;
        l_wdata <= bus.data_in;
        l_we    <= bus.write_enable;
        l_se    <= bus.sign_extend;
        l_size  <= decode_size(bus.mem_byte, bus.mem_half_word);
      end
      if (commit) begin
        error_q <= err;
        data_q  <= (c_we || err) ? 32'h0 : rdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_nx = RESP;
          end else begin
            cnt_nx   = 4'(LATENCY - 1);
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.data_out   = data_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
// Stimulus pushes expected responses; per-instance monitors pop and compare on resp_valid.
// Ports: none (top-level bench).
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   fails;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          id;
  } exp_t;

  exp_t qa[$];
  exp_t qz[$];
  int   ida;
  int   idz;
  int   last_z;

  dmem_responder_if ba ();
  dmem_responder_if bz ();

  dmem_responder #(.SIZE(16384), .LATENCY(2)) u_a (.clock(clk), .reset(rst_n), .bus(ba));
  dmem_responder #(.SIZE(16384), .LATENCY(0)) u_z (.clock(clk), .reset(rst_n), .bus(bz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (ba.resp_valid) begin
      if (qa.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL a_spurious: resp_valid with no pending request at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        chk($sformatf("a%0d_data", e.id), ba.data_out, e.data);
        chk($sformatf("a%0d_error", e.id), {31'b0, ba.error}, {31'b0, e.err});
        chk($sformatf("a%0d_latency", e.id), 32'(cyc - e.acc), 32'd3);
        chk($sformatf("a%0d_ready_in_resp", e.id), {31'b0, ba.req_ready}, 32'd0);
      end
    end
  end

  // Monitor for the LATENCY=0 instance; also checks response spacing.
  always @(negedge clk) begin
    exp_t e;
    if (bz.resp_valid) begin
      if (qz.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL z_spurious: resp_valid with no pending request at cycle %0d", cyc);
      end else begin
        e = qz.pop_front();
        chk($sformatf("z%0d_data", e.id), bz.data_out, e.data);
        chk($sformatf("z%0d_error", e.id), {31'b0, bz.error}, {31'b0, e.err});
        chk($sformatf("z%0d_latency", e.id), 32'(cyc - e.acc), 32'd1);
        chk($sformatf("z%0d_ready_in_resp", e.id), {31'b0, bz.req_ready}, 32'd0);
        if (last_z >= 0) chk($sformatf("z%0d_spacing", e.id), 32'(cyc - last_z), 32'd2);
        last_z = cyc;
      end
    end
  end

  task automatic issue_a(input logic [31:0] ad, input logic we, input logic b, input logic h,
                         input logic se, input logic [31:0] din, input logic [31:0] exp,
                         input logic er, input bit push);
    exp_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (!ba.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ba.req_ready) begin
      checks++;
      fails++;
      $display("FAIL a_ready_timeout: req_ready stuck %0d want 1", ba.req_ready);
    end
    ba.addr = ad;
    ba.write_enable = we;
    ba.mem_byte = b;
    ba.mem_half_word = h;
    ba.sign_extend = se;
    ba.data_in = din;
    ba.req_valid = 1'b1;
    if (push) begin
      e.data = exp;
      e.err = er;
      e.acc = cyc;
      e.id = ida;
      qa.push_back(e);
    end
    ida++;
    @(posedge clk);
    #1;
    // Scramble the fields while the access is pending; they must be ignored.
    ba.req_valid = 1'b0;
    ba.addr = $urandom;
    ba.data_in = $urandom;
    ba.write_enable = ~we;
    ba.mem_byte = ~b;
    ba.mem_half_word = ~h;
    ba.sign_extend = ~se;
  endtask

  task automatic issue_z(input logic [31:0] ad, input logic we, input logic b, input logic h,
                         input logic se, input logic [31:0] din, input logic [31:0] exp,
                         input logic er);
    exp_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (!bz.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bz.req_ready) begin
      checks++;
      fails++;
      $display("FAIL z_ready_timeout: req_ready stuck %0d want 1", bz.req_ready);
    end
    bz.addr = ad;
    bz.write_enable = we;
    bz.mem_byte = b;
    bz.mem_half_word = h;
    bz.sign_extend = se;
    bz.data_in = din;
    bz.req_valid = 1'b1;
    e.data = exp;
    e.err = er;
    e.acc = cyc;
    e.id = idz;
    qz.push_back(e);
    idz++;
    @(posedge clk);
  endtask

  initial begin
    int n;
    cyc = 0; checks = 0; fails = 0; ida = 0; idz = 0; last_z = -1;
    rst_n = 1'b0;
    ba.req_valid = 0; ba.addr = 0; ba.write_enable = 0; ba.mem_byte = 0;
    ba.mem_half_word = 0; ba.sign_extend = 0; ba.data_in = 0;
    bz.req_valid = 0; bz.addr = 0; bz.write_enable = 0; bz.mem_byte = 0;
    bz.mem_half_word = 0; bz.sign_extend = 0; bz.data_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", {31'b0, ba.req_ready}, 32'd1);
    chk("rst_a_resp_valid", {31'b0, ba.resp_valid}, 32'd0);
    chk("rst_a_data_out", ba.data_out, 32'h0);
    chk("rst_a_error", {31'b0, ba.error}, 32'd0);
    chk("rst_z_ready", {31'b0, bz.req_ready}, 32'd1);
    chk("rst_z_data_out", bz.data_out, 32'h0);
    rst_n = 1'b1;

    //      addr        we b  h  se data_in       expected      err push
    issue_a(32'h100,    1, 0, 0, 0, 32'hDEADBEEF, 32'h00000000, 0, 1);
    issue_a(32'h100,    0, 0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 1);
    issue_a(32'h101,    0, 1, 0, 1, 32'h0,        32'hFFFFFFAD, 0, 1);
    issue_a(32'h101,    0, 1, 0, 0, 32'h0,        32'h000000AD, 0, 1);
    issue_a(32'h102,    0, 0, 1, 1, 32'h0,        32'hFFFFBEEF, 0, 1);
    issue_a(32'h100,    0, 0, 1, 0, 32'h0,        32'h0000DEAD, 0, 1);
    issue_a(32'h101,    0, 1, 1, 0, 32'h0,        32'h000000AD, 0, 1);
    issue_a(32'h200,    1, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 1);
    issue_a(32'h200,    1, 0, 1, 0, 32'h12345678, 32'h00000000, 0, 1);
    issue_a(32'h200,    0, 0, 0, 0, 32'h0,        32'h56780000, 0, 1);
    issue_a(32'h102,    0, 0, 0, 0, 32'h0,        32'h00000000, 1, 1);
    issue_a(32'h3FFC,   1, 0, 0, 0, 32'h01020304, 32'h00000000, 0, 1);
    issue_a(32'h3FFE,   1, 0, 0, 0, 32'hAABBCCDD, 32'h00000000, 1, 1);
    issue_a(32'h3FFC,   0, 0, 0, 0, 32'h0,        32'h01020304, 0, 1);
    issue_a(32'h3FFF,   0, 1, 0, 0, 32'h0,        32'h00000004, 0, 1);
    issue_a(32'h3FFF,   0, 0, 1, 0, 32'h0,        32'h00000000, 1, 1);
    issue_a(32'h4000,   0, 1, 0, 0, 32'h0,        32'h00000000, 1, 1);
    issue_a(32'h103,    1, 1, 0, 0, 32'h123456A5, 32'h00000000, 0, 1);
    issue_a(32'h100,    0, 0, 0, 0, 32'h0,        32'hDEADBEA5, 0, 1);
    issue_a(32'h300,    1, 0, 0, 0, 32'h11223344, 32'h00000000, 0, 1);
    issue_a(32'h100,    0, 0, 0, 1, 32'h0,        32'hDEADBEA5, 0, 1);

    // Store aborted by reset while waiting: no response, mem untouched.
    issue_a(32'h300,    1, 0, 0, 0, 32'hAABBCCDD, 32'h00000000, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ready", {31'b0, ba.req_ready}, 32'd1);
    chk("abort_rst_resp_valid", {31'b0, ba.resp_valid}, 32'd0);
    chk("abort_rst_data_out", ba.data_out, 32'h0);
    chk("abort_rst_error", {31'b0, ba.error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_after_release", {31'b0, ba.req_ready}, 32'd1);
    issue_a(32'h300,    0, 0, 0, 0, 32'h0,        32'h11223344, 0, 1);

    // Zero-latency instance, requests held back-to-back.
    issue_z(32'h10, 1, 0, 0, 0, 32'hCAFEF00D, 32'h00000000, 0);
    issue_z(32'h10, 0, 0, 0, 0, 32'h0,        32'hCAFEF00D, 0);
    issue_z(32'h13, 0, 1, 0, 1, 32'h0,        32'h0000000D, 0);
    issue_z(32'h10, 0, 0, 1, 1, 32'h0,        32'hFFFFCAFE, 0);
    issue_z(32'h11, 0, 0, 0, 0, 32'h0,        32'h00000000, 1);
    @(negedge clk);
    bz.req_valid = 1'b0;

    n = 0;
    while ((qa.size() != 0 || qz.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("z_queue_drained", 32'(qz.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder. It is the memory-side end of the processor's data-memory port: the same address, data, write_enable and byte/half-word/sign-extend signalling, plus a valid/ready request handshake and a response strobe. It lets the processor and benches model a memory with configurable wait states in place of the zero-latency array. Storage is a byte array `mem`, big-endian, with bit 0 as the MSB of 32-bit buses.

Parameters:
SIZE, 16384, memory depth in bytes; also the upper address bound.
LATENCY, 2, wait cycles between request acceptance and response (0..15).

Ports:
clock  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  input  1  processor presents a request.
req_ready  output  1  responder can accept a request.
addr  input  [0:31]  byte address.
write_enable  input  1  1 = store, 0 = load.
mem_byte  input  1  byte access.
mem_half_word  input  1  half-word access; if mem_byte and mem_half_word are both 0, the access is a word.
sign_extend  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
data_in  input  [0:31]  store data; the sub-word is taken from the low-order bits.
resp_valid  output  1  one-cycle pulse; the response is valid.
data_out  output  [0:31]  load data; 0 for stores and for errors.
error  output  1  qualified by resp_valid: the access was misaligned or out of range.

Behaviour:
- Reset (reset=0, async): state IDLE, req_ready=1, resp_valid=0, data_out=0, error=0, wait counter=0. `mem` contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid=1, latch addr, data_in, write_enable and the three size/extend flags.
  - LATENCY=0: go to RESP.
  - Otherwise: load counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle; at 0, commit the access and go to RESP. Input changes during WAIT are ignored.
- Commit edge: for LATENCY=0 the commit is the acceptance edge; otherwise it is the WAIT-to-RESP edge.
  - Stores write `mem` on the commit edge.
  - Loads register data_out on the commit edge.
  - error is registered on the commit edge.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE. data_out and error hold until the next commit.
- Minimum spacing: a new request is accepted in IDLE only. Back-to-back throughput is one access per LATENCY+2 cycles.
- Sub-word size priority: if mem_byte=1, the access is a byte; else if mem_half_word=1, it is a half-word; else it is a word.
- Byte-lane mapping, big-endian, with a = latched addr:
  - Word store: mem[a]=data_in[0:7], mem[a+1]=data_in[8:15], mem[a+2]=data_in[16:23], mem[a+3]=data_in[24:31].
  - Half-word store: mem[a]=data_in[16:23], mem[a+1]=data_in[24:31].
  - Byte store: mem[a]=data_in[24:31].
  - Loads mirror the store lanes. The sub-word is placed in data_out[24:31] (byte) or data_out[16:31] (half-word). The upper bits are filled with the sub-word MSB if sign_extend=1, else with 0. sign_extend is ignored for word loads.
- Error conditions:
  - Half-word access with addr[31]=1.
  - Word access with addr[30:31] not equal to 00.
  - addr + access_size > SIZE.
  - On error: no write occurs, data_out=0, error=1 with resp_valid.
- Reset mid-operation: if reset is asserted in WAIT, the pending access is aborted. A store whose commit edge has not occurred never modifies `mem`. The block returns to IDLE with the outputs at their reset values.
- resp_valid and req_ready are never 1 in the same cycle.

Decomposition:
- Shared package, dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - access-size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
  - size-to-byte-count constants;
  - function load_extend(raw, size, sign_extend).
- One natural sub-module, dmem_lane_align: combinational lane steering for store bytes and load extension. It holds no state. The FSM, counter, latch and array stay in dmem_responder.

Test Plan:
- Preload mem[0x100..0x103]=DE AD BE EF. Word load of 0x100 with LATENCY=2 → resp_valid rises 3 cycles after acceptance; data_out=DEADBEEF, error=0.
- Byte load of 0x101:
  - sign_extend=1 → FFFFFFAD.
  - sign_extend=0 → 000000AD.
  - Half-word load of 0x102 with sign_extend=1 → FFFFBEEF.
- Half-word store data_in=12345678 to 0x200 → mem[0x200]=56, mem[0x201]=78; a word load of 0x200 returns 56780000.
- Word load of 0x102 → error=1, data_out=0. Word store of 0x3FFE → error=1, `mem` unchanged. Word access at 0x3FFC → error=0.
- Word store AABBCCDD to 0x300 with reset pulsed low during WAIT → mem[0x300..0x303] unchanged; req_ready=1 one edge after reset rises (after release).
- LATENCY=0 build: back-to-back requests → resp_valid every 2nd cycle; req_ready=0 during RESP.
